stream_upsizer: RTL and testbench
=================================

// Module: stream_upsizer
// PURPOSE
//  Packs RATIO narrow beats from a valid/ready stream into one wide word.
//  Sits directly downstream of the gray-pointer CDC FIFO, in the destination
//  clock domain, so that narrow crossings feed a wide datapath.
//  Packet boundaries (last) and idle timeouts close partially filled words;
//  the per-lane strobe marks the valid lanes.
// PARAMETERS
//  IN_WIDTH  8   width of one input beat
//  RATIO     4   beats per output word; power of two, >=1
//  TIMEOUT   16  idle cycles before a partial word is flushed; 0 = never flush
// PORTS
//  clk_i       in   1               clock
//  rst_i       in   1               asynchronous, active-high reset
//  in_data_i   in   IN_WIDTH        input beat
//  in_last_i   in   1               beat closes packet
//  in_valid_i  in   1               input handshake
//  in_ready_o  out  1               input handshake
//  out_data_o  out  IN_WIDTH*RATIO  packed word; lane k = bits [k*IN_WIDTH +: IN_WIDTH]
//  out_strb_o  out  RATIO           lane k holds valid data
//  out_last_o  out  1               word carries a packet's last beat
//  out_valid_o out  1               output handshake
//  out_ready_i in   1               output handshake
// BEHAVIOUR
//  - Reset (async assert, sync release): state FILL, cnt=0, idle=0.
//    out_data_o='0, out_strb_o='0, out_last_o=0, out_valid_o=0, in_ready_o=1.
//  - Single word register; a beat writes lane cnt and sets strb[cnt].
//  - Lane 0 is filled first. Unwritten lanes read 0.
//  - in_ready_o = (state==FILL) | out_ready_i. It never depends on in_valid_i.
//    out_valid_o never depends on out_ready_i.
//  - State FILL (out_valid_o=0), on an accepted beat:
//      cnt==RATIO-1 or in_last_i -> HOLD, out_last_o=in_last_i, cnt=0;
//      otherwise                 -> cnt+1.
//  - Timeout, in FILL with cnt>0 and no accepted beat:
//      idle increments each cycle; at idle==TIMEOUT-1 -> HOLD with
//      out_last_o=0 and the current strobe;
//      idle clears on any accepted beat and on entering HOLD;
//      TIMEOUT=0 removes the timer entirely.
//  - State HOLD (out_valid_o=1): outputs are stable until out_ready_i.
//    On out_ready_i:
//      no accepted beat -> FILL, data/strb/last cleared;
//      simultaneous accepted beat -> the word is replaced by a fresh one:
//        lane 0 = in_data_i, strb = 'b1;
//        if RATIO==1 or in_last_i -> stay HOLD (back-to-back), else FILL, cnt=1.
//  - Throughput: 1 beat/cycle sustained while out_ready_i=1.
//    Latency: word visible the cycle after the completing beat.
//  - cnt is $clog2(RATIO) bits (min 1) and wraps only via reset to 0 on
//    completion. Idle counter is $clog2(TIMEOUT+1) bits and saturates.
//  - Reset mid-word: the partial word is discarded, no output emitted.
//  - A beat with in_last_i at cnt==0 yields strb='b0001.
// STRUCTURE
//  - Shared package stream_pkg: upsizer_state_e {FILL, HOLD}.
//  - Lane/strobe helper function lane_mask(cnt) -> RATIO-bit one-hot.
//  - Sub-module stream_idle_timer: clear/enable/expire counter, generated only
//    when TIMEOUT>0.
//  - All flops in one always_ff with posedge rst_i; no latches, no
//    combinational in->out path except in_ready_o from out_ready_i.
// TESTING
//  Defaults unless stated (IN_WIDTH=8, RATIO=4, TIMEOUT=16).
//  1. Beats 11,22,33,44 back-to-back, out_ready_i=1
//     -> one word 0x44332211, strb 1111, last 0, one cycle after beat 4.
//  2. Beats AA,BB with last on BB
//     -> word 0x0000BBAA, strb 0011, last 1; next word restarts at lane 0.
//  3. Single beat 5A, then idle 16 cycles
//     -> word 0x0000005A, strb 0001, last 0 on cycle 16; no flush if TIMEOUT=0.
//  4. out_ready_i=0 for 10 cycles while holding
//     -> outputs stable, in_ready_o=0; release with in_valid_i=1
//     -> old word taken, new beat lands in lane 0 the same cycle.
//  5. RATIO=1, continuous beats, out_ready_i=1
//     -> one word per cycle, out_valid_o stays 1, no bubbles.
//  6. rst_i pulsed after 2 of 4 beats
//     -> all outputs 0 immediately; the next 4 beats give one full word.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared stream types and helpers for the narrow-to-wide upsizer.
package stream_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } upsizer_state_e;

    localparam int unsigned MAX_RATIO = 32;

    // One-hot lane select; callers truncate to their own RATIO width.
    function automatic logic [MAX_RATIO-1:0] lane_mask(input logic [31:0] idx);
        return MAX_RATIO'(1) << idx;
    endfunction

endpackage

// File: rtl/stream_idle_timer.sv
// Next-state logic for the saturating idle counter that flushes partial words.
module stream_idle_timer #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned IW      = $clog2(TIMEOUT + 1)
) (
    input  logic [IW-1:0] idle_q_i,
    input  logic          clear_i,
    input  logic          enable_i,
    output logic [IW-1:0] idle_d_o,
    output logic          expire_o
);

    localparam logic [IW-1:0] LAST_IDLE = IW'(TIMEOUT - 1);

    always_comb begin
        expire_o = enable_i && (idle_q_i == LAST_IDLE);
        idle_d_o = idle_q_i;
        // Expiry moves the upsizer to HOLD, which also restarts the count.
        if (clear_i || expire_o) begin
            idle_d_o = '0;
        end else if (enable_i && (idle_q_i != '1)) begin
            idle_d_o = idle_q_i + 1'b1;
        end
    end

endmodule

// File: rtl/stream_upsizer.sv
// Packs RATIO narrow valid/ready beats into one wide word with lane strobes;
// packet ends and idle timeouts close partial words.
//
//  state | meaning
//  FILL  | collecting beats into the word register, out_valid_o low
//  HOLD  | word complete, out_valid_o high until out_ready_i
module stream_upsizer
    import stream_pkg::*;
#(
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned RATIO    = 4,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [IN_WIDTH-1:0]       in_data_i,
    input  logic                      in_last_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    output logic [IN_WIDTH*RATIO-1:0] out_data_o,
    output logic [RATIO-1:0]          out_strb_o,
    output logic                      out_last_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i
);

    localparam int unsigned OW = IN_WIDTH * RATIO;
    localparam int unsigned CW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int unsigned IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

    upsizer_state_e state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OW-1:0]    data_q, data_d;
    logic [RATIO-1:0] strb_q, strb_d;
    logic             last_q, last_d;
    logic [IW-1:0]    idle_q, idle_d;
    logic             expire;
    logic             in_ready;
    logic             accept;

    assign in_ready = (state_q == FILL) || out_ready_i;
    assign accept   = in_valid_i && in_ready;

    generate
        if (TIMEOUT > 0) begin : g_timer
            stream_idle_timer #(
                .TIMEOUT (TIMEOUT),
                .IW      (IW)
            ) u_idle_timer (
                .idle_q_i (idle_q),
                .clear_i  (accept),
                .enable_i ((state_q == FILL) && (cnt_q != '0) && !accept),
                .idle_d_o (idle_d),
                .expire_o (expire)
            );
        end else begin : g_no_timer
            logic unused_idle;
            assign unused_idle = ^idle_q;
            assign idle_d      = '0;
            assign expire      = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        strb_d  = strb_q;
        last_d  = last_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    data_d[cnt_q*IN_WIDTH +: IN_WIDTH] = in_data_i;
                    strb_d = strb_q | RATIO'(lane_mask(32'(cnt_q)));
                    if ((cnt_q == LAST_LANE) || in_last_i) begin
                        state_d = HOLD;
                        last_d  = in_last_i;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (expire) begin
                    state_d = HOLD;
                    last_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (out_ready_i) begin
                    data_d = '0;
                    strb_d = '0;
                    last_d = 1'b0;
                    cnt_d  = '0;
                    state_d = FILL;
                    // A beat accepted alongside the drain starts the next word at lane 0.
                    if (accept) begin
                        data_d[IN_WIDTH-1:0] = in_data_i;
                        strb_d = RATIO'(1);
                        if ((RATIO == 1) || in_last_i) begin
                            state_d = HOLD;
                            last_d  = in_last_i;
                        end else begin
                            cnt_d = CW'(1);
                        end
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= FILL;
            cnt_q   <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            last_q  <= 1'b0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            last_q  <= last_d;
            idle_q  <= idle_d;
        end
    end

    assign in_ready_o  = in_ready;
    assign out_data_o  = data_q;
    assign out_strb_o  = strb_q;
    assign out_last_o  = last_q;
    assign out_valid_o = (state_q == HOLD);

endmodule

// File: tb/tb_stream_upsizer.sv
// Directed bench for stream_upsizer: default, no-timeout and RATIO=1 instances
// share one input stream.
module tb_stream_upsizer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;

    logic        m_in_ready, m_last, m_valid;
    logic [31:0] m_data;
    logic [3:0]  m_strb;
    logic        t_in_ready, t_last, t_valid;
    logic [31:0] t_data;
    logic [3:0]  t_strb;
    logic        r_in_ready, r_last, r_valid;
    logic [7:0]  r_data;
    logic [0:0]  r_strb;

    int checks = 0;
    int failures = 0;
    logic rdy_pre;

    always #5 clk = ~clk;

    stream_upsizer #(.IN_WIDTH(8), .RATIO(4), .TIMEOUT(16)) u_main (
        .clk_i(clk), .rst_i(rst), .in_data_i(in_data), .in_last_i(in_last),
        .in_valid_i(in_valid), .in_ready_o(m_in_ready), .out_data_o(m_data),
        .out_strb_o(m_strb), .out_last_o(m_last), .out_valid_o(m_valid),
        .out_ready_i(out_ready));

    stream_upsizer #(.IN_WIDTH(8), .RATIO(4), .TIMEOUT(0)) u_t0 (
        .clk_i(clk), .rst_i(rst), .in_data_i(in_data), .in_last_i(in_last),
        .in_valid_i(in_valid), .in_ready_o(t_in_ready), .out_data_o(t_data),
        .out_strb_o(t_strb), .out_last_o(t_last), .out_valid_o(t_valid),
        .out_ready_i(out_ready));

    stream_upsizer #(.IN_WIDTH(8), .RATIO(1), .TIMEOUT(16)) u_r1 (
        .clk_i(clk), .rst_i(rst), .in_data_i(in_data), .in_last_i(in_last),
        .in_valid_i(in_valid), .in_ready_o(r_in_ready), .out_data_o(r_data),
        .out_strb_o(r_strb), .out_last_o(r_last), .out_valid_o(r_valid),
        .out_ready_i(out_ready));

    typedef struct {
        logic        v;
        logic        l;
        logic [7:0]  d;
        logic        r;
        logic        e_rdy;
        logic        e_val;
        logic [31:0] e_data;
        logic [3:0]  e_strb;
        logic        e_last;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle: inputs after the falling edge, in_ready sampled before
    // the rising edge, registered outputs sampled just after it.
    task automatic cyc(input logic v, input logic l, input logic [7:0] d, input logic r);
        @(negedge clk);
        in_valid  = v;
        in_last   = l;
        in_data   = d;
        out_ready = r;
        #1;
        rdy_pre = m_in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_main(input string tag, input logic val, input logic [31:0] data,
                            input logic [3:0] strb, input logic last);
        chk({tag, ".valid"}, 64'(m_valid), 64'(val));
        chk({tag, ".data"},  64'(m_data),  64'(data));
        chk({tag, ".strb"},  64'(m_strb),  64'(strb));
        chk({tag, ".last"},  64'(m_last),  64'(last));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        // Test 1 and 2 plus back-to-back HOLD cases, out_ready=1 throughout.
        tbl[0] = '{1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 32'h0000_0011, 4'b0001, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 8'h22, 1'b1, 1'b1, 1'b0, 32'h0000_2211, 4'b0011, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 8'h33, 1'b1, 1'b1, 1'b0, 32'h0033_2211, 4'b0111, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 8'h44, 1'b1, 1'b1, 1'b1, 32'h4433_2211, 4'b1111, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 8'hAA, 1'b1, 1'b1, 1'b0, 32'h0000_00AA, 4'b0001, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 8'hBB, 1'b1, 1'b1, 1'b1, 32'h0000_BBAA, 4'b0011, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 4'b0000, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 8'hCC, 1'b1, 1'b1, 1'b1, 32'h0000_00CC, 4'b0001, 1'b1};
        tbl[8] = '{1'b1, 1'b1, 8'hDD, 1'b1, 1'b1, 1'b1, 32'h0000_00DD, 4'b0001, 1'b1};
        tbl[9] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 4'b0000, 1'b0};

        // Reset state
        #12;
        chk_main("reset", 1'b0, 32'h0, 4'h0, 1'b0);
        chk("reset.in_ready", 64'(m_in_ready), 64'(1'b1));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].r);
            chk($sformatf("vec%0d.in_ready", i), 64'(rdy_pre), 64'(tbl[i].e_rdy));
            chk_main($sformatf("vec%0d", i), tbl[i].e_val, tbl[i].e_data, tbl[i].e_strb, tbl[i].e_last);
        end

        // Test 3: idle flush after 16 cycles; the TIMEOUT=0 instance never flushes.
        cyc(1'b1, 1'b0, 8'h5A, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b1);
            if (k < 16) chk($sformatf("idle%0d.valid", k), 64'(m_valid), 64'(1'b0));
        end
        chk_main("timeout", 1'b1, 32'h0000_005A, 4'b0001, 1'b0);
        chk("timeout.t0_valid", 64'(t_valid), 64'(1'b0));
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk_main("timeout_drain", 1'b0, 32'h0, 4'h0, 1'b0);
        for (int k = 0; k < 20; k++) cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("t0_long_idle.valid", 64'(t_valid), 64'(1'b0));
        chk("t0_long_idle.data", 64'(t_data), 64'(32'h0000_005A));
        cyc(1'b1, 1'b1, 8'h6B, 1'b1);
        chk("t0_close.data", 64'(t_data), 64'(32'h0000_6B5A));
        chk("t0_close.strb", 64'(t_strb), 64'(4'b0011));
        chk("t0_close.last", 64'(t_last), 64'(1'b1));
        chk("t0_close.valid", 64'(t_valid), 64'(1'b1));
        cyc(1'b0, 1'b0, 8'h00, 1'b1);

        // Test 4: backpressure while holding, then release with a beat.
        cyc(1'b1, 1'b0, 8'h01, 1'b1);
        cyc(1'b1, 1'b0, 8'h02, 1'b1);
        cyc(1'b1, 1'b0, 8'h03, 1'b1);
        cyc(1'b1, 1'b0, 8'h04, 1'b1);
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, 1'b0, 8'h55, 1'b0);
            chk($sformatf("stall%0d.in_ready", k), 64'(rdy_pre), 64'(1'b0));
            chk_main($sformatf("stall%0d", k), 1'b1, 32'h0403_0201, 4'b1111, 1'b0);
        end
        cyc(1'b1, 1'b0, 8'h55, 1'b1);
        chk("release.in_ready", 64'(rdy_pre), 64'(1'b1));
        chk_main("release", 1'b0, 32'h0000_0055, 4'b0001, 1'b0);
        cyc(1'b1, 1'b0, 8'h66, 1'b1);
        cyc(1'b1, 1'b0, 8'h77, 1'b1);
        cyc(1'b1, 1'b0, 8'h88, 1'b1);
        chk_main("after_release", 1'b1, 32'h8877_6655, 4'b1111, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);

        // Test 5: RATIO=1 streams one word per cycle without bubbles.
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 1'b0, 8'(8'h10 + k), 1'b1);
            chk($sformatf("r1_%0d.valid", k), 64'(r_valid), 64'(1'b1));
            chk($sformatf("r1_%0d.data", k), 64'(r_data), 64'(8'h10 + k));
            chk($sformatf("r1_%0d.strb", k), 64'(r_strb), 64'(1'b1));
        end
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("r1_drain.valid", 64'(r_valid), 64'(1'b0));

        // Test 6: reset mid-word discards the partial word.
        cyc(1'b1, 1'b0, 8'hA1, 1'b1);
        cyc(1'b1, 1'b0, 8'hA2, 1'b1);
        chk("pre_reset.data", 64'(m_data), 64'(32'h0000_A2A1));
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        #1;
        chk_main("mid_reset", 1'b0, 32'h0, 4'h0, 1'b0);
        chk("mid_reset.in_ready", 64'(m_in_ready), 64'(1'b1));
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 1'b0, 8'hB1, 1'b1);
        cyc(1'b1, 1'b0, 8'hB2, 1'b1);
        cyc(1'b1, 1'b0, 8'hB3, 1'b1);
        chk("post_reset_partial.valid", 64'(m_valid), 64'(1'b0));
        cyc(1'b1, 1'b0, 8'hB4, 1'b1);
        chk_main("post_reset", 1'b1, 32'hB4B3_B2B1, 4'b1111, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
